// File: rtl/fir_mac_sequencer_if.sv
// Sample, coefficient-write and result signals of the symmetric FIR engine.
// The master side feeds samples and coefficients; the slave side is the engine.
interface fir_mac_sequencer_if #(
    parameter int TAPS = 12,
    parameter int DW   = 18
);
    localparam int CAW = $clog2(TAPS / 2);

    logic signed [DW-1:0]  in_sample;
    logic                  new_data;
    logic                  coef_we;
    logic        [CAW-1:0] coef_addr;
    logic signed [DW-1:0]  coef_wdata;
    logic signed [DW-1:0]  out_sample;
    logic                  data_ready;
    logic                  busy;
    logic                  overrun;
    logic                  coef_err;

    modport master (
        output in_sample, new_data, coef_we, coef_addr, coef_wdata,
        input  out_sample, data_ready, busy, overrun, coef_err
    );

    modport slave (
        input  in_sample, new_data, coef_we, coef_addr, coef_wdata,
        output out_sample, data_ready, busy, overrun, coef_err
    );
endinterface

// File: rtl/fir_mac_sequencer.sv
// Time-multiplexed symmetric FIR: circular delay line, one shared pre-adder,
// multiplier and accumulator stepping over one coefficient pair per clock.
module fir_mac_sequencer #(
    parameter int TAPS = 12,
    parameter int DW   = 18,
    parameter int FRAC = 12
) (
    input  logic                 clk,
    input  logic                 rst,
    fir_mac_sequencer_if.slave   bus
);
    localparam int HALF = TAPS / 2;
    localparam int PW   = $clog2(TAPS);
    localparam int KW   = $clog2(HALF);
    localparam int PRW  = 2 * DW + 1;
    localparam int ACW  = 2 * DW + 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        OUT  = 2'd2
    } state_t;

    state_t                 state_r;
    logic signed [DW-1:0]   dline_r [TAPS];
    logic signed [DW-1:0]   coef_r  [HALF];
    logic        [PW-1:0]   wr_ptr_r;
    logic        [PW-1:0]   newest_r;
    logic        [KW-1:0]   k_r;
    logic signed [ACW-1:0]  acc_r;
    logic signed [DW-1:0]   out_sample_r;
    logic                   data_ready_r;
    logic                   busy_r;
    logic                   overrun_r;
    logic                   coef_err_r;

    logic        [PW-1:0]   idx_a_s;
    logic        [PW:0]     sum_b_s;
    logic        [PW-1:0]   idx_b_s;
    logic signed [DW:0]     pre_s;
    logic signed [PRW-1:0]  prod_s;
    logic signed [ACW-1:0]  sh_s;
    logic signed [DW-1:0]   sat_s;
    logic                   addr_bad_s;

    // Power-on coefficient bank; the low half of the symmetric impulse response.
    function automatic logic signed [DW-1:0] coef_default(input int k);
        logic signed [DW-1:0] c;
        case (k)
            0:       c = DW'(32'sd80);
            1:       c = DW'(-32'sd467);
            2:       c = DW'(32'sd65);
            3:       c = DW'(-32'sd174);
            4:       c = DW'(-32'sd731);
            5:       c = DW'(32'sd2512);
            default: c = DW'(32'sd0);
        endcase
        return c;
    endfunction

    // Tap pair k: newest-k and its mirror newest-(TAPS-1-k) == newest+k+1, both mod TAPS.
    always_comb begin
        if (newest_r >= PW'(k_r)) begin
            idx_a_s = newest_r - PW'(k_r);
        end else begin
            idx_a_s = newest_r + PW'(TAPS) - PW'(k_r);
        end
        sum_b_s = {1'b0, newest_r} + (PW+1)'(k_r) + (PW+1)'(1);
        if (sum_b_s >= (PW+1)'(TAPS)) begin
            idx_b_s = PW'(sum_b_s - (PW+1)'(TAPS));
        end else begin
            idx_b_s = PW'(sum_b_s);
        end
    end

    // Shared pre-add and multiply for the current pair.
    always_comb begin
        pre_s  = {dline_r[idx_a_s][DW-1], dline_r[idx_a_s]}
               + {dline_r[idx_b_s][DW-1], dline_r[idx_b_s]};
        prod_s = PRW'(pre_s) * PRW'(coef_r[k_r]);
    end

    // Rescale to the sample format; out-of-range results clamp to the rails.
    always_comb begin
        sh_s = acc_r >>> FRAC;
        if ((&sh_s[ACW-1:DW-1]) || (~|sh_s[ACW-1:DW-1])) begin
            sat_s = sh_s[DW-1:0];
        end else if (sh_s[ACW-1]) begin
            sat_s = {1'b1, {(DW-1){1'b0}}};
        end else begin
            sat_s = {1'b0, {(DW-1){1'b1}}};
        end
        addr_bad_s = ({1'b0, bus.coef_addr} >= (KW+1)'(HALF));
    end

    // Sequencer, delay line, coefficient bank and sticky error flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= IDLE;
            wr_ptr_r     <= '0;
            newest_r     <= '0;
            k_r          <= '0;
            acc_r        <= '0;
            out_sample_r <= '0;
            data_ready_r <= 1'b0;
            busy_r       <= 1'b0;
            overrun_r    <= 1'b0;
            coef_err_r   <= 1'b0;
            for (int i = 0; i < TAPS; i++) dline_r[i] <= '0;
            for (int i = 0; i < HALF; i++) coef_r[i] <= coef_default(i);
        end else begin
            data_ready_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (bus.new_data) begin
                        dline_r[wr_ptr_r] <= bus.in_sample;
                        newest_r          <= wr_ptr_r;
                        wr_ptr_r          <= (wr_ptr_r == PW'(TAPS - 1)) ? '0 : wr_ptr_r + PW'(1);
                        acc_r             <= '0;
                        k_r               <= '0;
                        state_r           <= MAC;
                        busy_r            <= 1'b1;
                    end else begin
                        busy_r            <= 1'b0;
                    end
                    // A write colliding with an accepted sample is rejected, not deferred.
                    if (bus.coef_we) begin
                        if (bus.new_data || addr_bad_s) begin
                            coef_err_r <= 1'b1;
                        end else begin
                            coef_r[bus.coef_addr] <= bus.coef_wdata;
                        end
                    end
                end
                MAC: begin
                    acc_r  <= acc_r + ACW'(prod_s);
                    busy_r <= 1'b1;
                    if (k_r == KW'(HALF - 1)) begin
                        state_r <= OUT;
                    end else begin
                        k_r <= k_r + KW'(1);
                    end
                    if (bus.new_data) overrun_r  <= 1'b1;
                    if (bus.coef_we)  coef_err_r <= 1'b1;
                end
                OUT: begin
                    out_sample_r <= sat_s;
                    data_ready_r <= 1'b1;
                    busy_r       <= 1'b0;
                    state_r      <= IDLE;
                    if (bus.new_data) overrun_r  <= 1'b1;
                    if (bus.coef_we)  coef_err_r <= 1'b1;
                end
                default: begin
                    busy_r  <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign bus.out_sample = out_sample_r;
    assign bus.data_ready = data_ready_r;
    assign bus.busy       = busy_r;
    assign bus.overrun    = overrun_r;
    assign bus.coef_err   = coef_err_r;
endmodule

// File: tb/tb_fir_mac_sequencer.sv
// Self-checking bench for fir_mac_sequencer: directed scenarios plus random
// samples and coefficients compared against a direct-form convolution model.
module tb_fir_mac_sequencer;
    localparam int TAPS = 12;
    localparam int DW   = 18;
    localparam int FRAC = 12;
    localparam int HALF = 6;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fir_mac_sequencer_if #(.TAPS(TAPS), .DW(DW)) bus ();

    fir_mac_sequencer #(.TAPS(TAPS), .DW(DW), .FRAC(FRAC)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int     n_checks = 0;
    int     n_fail   = 0;
    longint coef_m [HALF];
    longint dflt   [HALF] = '{80, -467, 65, -174, -731, 2512};
    longint imp    [TAPS] = '{80, -467, 65, -174, -731, 2512, 2512, -731, -174, 65, -467, 80};
    int     hist [$];

    task automatic check_val(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // y[n] = sat(floor(sum_t h[t]*x[n-t] / 2^FRAC)) with h[t] = h[TAPS-1-t].
    function automatic longint model_out();
        longint acc;
        longint xv;
        int     n;
        int     k;
        acc = 0;
        n   = hist.size();
        for (int t = 0; t < TAPS; t++) begin
            k   = (t < HALF) ? t : TAPS - 1 - t;
            xv  = (t < n) ? longint'(hist[n-1-t]) : 0;
            acc = acc + coef_m[k] * xv;
        end
        acc = acc >>> FRAC;
        if (acc > 131071) acc = 131071;
        else if (acc < -131072) acc = -131072;
        return acc;
    endfunction

    task automatic model_reset();
        hist.delete();
        for (int i = 0; i < HALF; i++) coef_m[i] = dflt[i];
    endtask

    task automatic do_reset();
        bus.new_data = 1'b0;
        bus.coef_we  = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_val("rst_out_sample", bus.out_sample, 0);
        check_val("rst_data_ready", bus.data_ready, 0);
        check_val("rst_busy", bus.busy, 0);
        check_val("rst_overrun", bus.overrun, 0);
        check_val("rst_coef_err", bus.coef_err, 0);
        model_reset();
    endtask

    task automatic wait_ready(output int lat);
        lat = -1;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (bus.data_ready) begin
                lat = i;
                break;
            end
        end
    endtask

    // Called at a negedge; returns at the negedge where data_ready is seen.
    task automatic send(input int v, input string tag, output longint got);
        longint exp;
        int     lat;
        bus.in_sample = DW'(v);
        bus.new_data  = 1'b1;
        hist.push_back(v);
        exp = model_out();
        @(negedge clk);
        bus.new_data = 1'b0;
        check_val({tag, "_busy"}, bus.busy, 1);
        check_val({tag, "_ready_width"}, bus.data_ready, 0);
        wait_ready(lat);
        check_val({tag, "_latency"}, lat, 7);
        got = bus.out_sample;
        if (lat > 0) begin
            check_val({tag, "_out"}, bus.out_sample, exp);
            check_val({tag, "_idle"}, bus.busy, 0);
        end
    endtask

    task automatic write_coef(input int a, input int v);
        bus.coef_we    = 1'b1;
        bus.coef_addr  = 3'(a);
        bus.coef_wdata = DW'(v);
        if (a < HALF) coef_m[a] = v;
        @(negedge clk);
        bus.coef_we = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        longint got;
        longint outs [TAPS];
        int     lat;
        int     cnt;

        rst = 1'b1;
        bus.in_sample  = '0;
        bus.new_data   = 1'b0;
        bus.coef_we    = 1'b0;
        bus.coef_addr  = '0;
        bus.coef_wdata = '0;
        @(negedge clk);
        do_reset();

        // Impulse and DC against both the model and fixed expectations.
        for (int i = 0; i < TAPS; i++) begin
            send((i == 0) ? 4096 : 0, "impulse", got);
            check_val("impulse_const", got, imp[i]);
        end
        for (int i = 0; i < 14; i++) begin
            send(4096, "dc", got);
            if (i >= 11) check_val("dc_const", got, 2570);
        end

        // Random coefficients and samples.
        for (int r = 0; r < 3; r++) begin
            for (int k = 0; k < HALF; k++) begin
                write_coef(k, int'($urandom_range(0, 8191)) - 4096);
            end
            for (int i = 0; i < 15; i++) begin
                send(int'($urandom_range(0, 262143)) - 131072, "random", got);
            end
        end
        check_val("random_no_err", bus.coef_err, 0);

        // Out-of-range coefficient address.
        do_reset();
        write_coef(6, 123);
        check_val("bad_addr_err", bus.coef_err, 1);
        send(4096, "bad_addr_coef_kept", got);

        // Saturation at both rails.
        do_reset();
        for (int k = 0; k < 5; k++) write_coef(k, 0);
        write_coef(5, 131071);
        for (int i = 0; i < TAPS; i++) begin
            send(131071, "sat_pos", got);
            if (i == TAPS - 1) check_val("sat_pos_const", got, 131071);
        end
        for (int i = 0; i < TAPS; i++) begin
            send(-131072, "sat_neg", got);
            if (i == TAPS - 1) check_val("sat_neg_const", got, -131072);
        end

        // Overrun: second strobe three cycles in is dropped.
        do_reset();
        bus.in_sample = DW'(1000);
        bus.new_data  = 1'b1;
        hist.push_back(1000);
        @(negedge clk);
        bus.new_data = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_val("ovr_before", bus.overrun, 0);
        bus.in_sample = DW'(77);
        bus.new_data  = 1'b1;
        @(negedge clk);
        bus.new_data = 1'b0;
        check_val("ovr_set", bus.overrun, 1);
        wait_ready(lat);
        check_val("ovr_latency", lat, 4);
        check_val("ovr_out", bus.out_sample, 19);
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus.data_ready) cnt++;
        end
        check_val("ovr_single_ready", cnt, 0);
        check_val("ovr_sticky", bus.overrun, 1);
        send(500, "ovr_advanced_once", got);

        // Coefficient write while busy is rejected; same write in IDLE lands.
        do_reset();
        bus.in_sample = DW'(4096);
        bus.new_data  = 1'b1;
        hist.push_back(4096);
        @(negedge clk);
        bus.new_data   = 1'b0;
        bus.coef_we    = 1'b1;
        bus.coef_addr  = 3'd2;
        bus.coef_wdata = DW'(1000);
        @(negedge clk);
        bus.coef_we = 1'b0;
        check_val("busy_write_err", bus.coef_err, 1);
        wait_ready(lat);
        check_val("busy_write_latency", lat, 6);
        check_val("busy_write_old_coef", bus.out_sample, 80);
        write_coef(2, 1000);
        check_val("err_sticky", bus.coef_err, 1);
        for (int i = 0; i < TAPS; i++) send(0, "flush", got);
        for (int i = 0; i < TAPS; i++) begin
            send((i == 0) ? 4096 : 0, "new_coef_impulse", got);
            outs[i] = got;
        end
        check_val("new_coef_tap2", outs[2], 1000);
        check_val("new_coef_tap9", outs[9], 1000);

        // Reset in the middle of MAC aborts the computation.
        bus.in_sample = DW'(4096);
        bus.new_data  = 1'b1;
        @(negedge clk);
        bus.new_data = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_val("midrst_out", bus.out_sample, 0);
        check_val("midrst_ready", bus.data_ready, 0);
        check_val("midrst_busy", bus.busy, 0);
        check_val("midrst_overrun", bus.overrun, 0);
        check_val("midrst_coef_err", bus.coef_err, 0);
        model_reset();
        cnt = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (bus.data_ready) cnt++;
        end
        check_val("midrst_no_ready", cnt, 0);
        for (int i = 0; i < TAPS; i++) begin
            send((i == 0) ? 4096 : 0, "post_rst_impulse", got);
            check_val("post_rst_impulse_const", got, imp[i]);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
